// File: rtl/i2c_sensor_target_pkg.sv
// i2c_sensor_target_pkg: state encoding, register map and read mux shared by the I2C sensor target
package i2c_sensor_target_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK, S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
  } state_t;
  localparam logic [7:0] REG_TEMP   = 8'h00;
  localparam logic [7:0] REG_FRAC   = 8'h0F;
  localparam logic [7:0] REG_CFG_WR = 8'h09;
  localparam logic [7:0] REG_CFG_RD = 8'h03;
  function automatic logic [7:0] reg_read(input logic [7:0] ptr, input logic [7:0] t_int,
                                          input logic [7:0] t_frac, input logic [7:0] cfg);
    return ptr == REG_TEMP ? t_int : ptr == REG_FRAC ? t_frac : ptr == REG_CFG_RD ? cfg : 8'h00;
  endfunction
  function automatic logic is_ack(input state_t s);
    return s inside {S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK};
  endfunction
endpackage

// File: rtl/i2c_sensor_target_line_sync.sv
// i2c_line_sync: SCL/SDA synchronizers with START, STOP and SCL edge detection
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q, scl_s, sda_s;
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  // synchronizer chains plus one-cycle-old copies for edge detection; idle bus level is high
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= SYNC_STAGES'({scl_sync_q, i_scl});
      sda_sync_q <= SYNC_STAGES'({sda_sync_q, i_sda});
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  assign o_sda      = sda_s;
  assign o_scl_rise = scl_s & ~scl_prev_q;
  assign o_scl_fall = ~scl_s & scl_prev_q;
  assign o_start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign o_stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
endmodule

// File: rtl/i2c_sensor_target.sv
// i2c_sensor_target: I2C target exposing a temperature snapshot and one config register
module i2c_sensor_target
  import i2c_sensor_target_pkg::*;
#(
  parameter logic [6:0] ADDR7       = 7'h4E,
  parameter logic [7:0] CFG_RESET   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  input  logic [7:0] i_temp_int,
  input  logic [7:0] i_temp_frac,
  output logic [7:0] o_cfg,
  output logic       o_cfg_wr,
  output logic       o_busy
);
  logic sda_s, scl_rise, scl_fall, start, stop;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, tx_q, tx_d, cfg_q, cfg_d;
  logic [7:0] snap_int_q, snap_int_d, snap_frac_q, snap_frac_d;
  logic phase_q, phase_d, cfg_wr_q, cfg_wr_d, busy_q, busy_d;
  logic [7:0] byte_in;
  logic last, addr_hit, in_rx, in_ack;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_scl     (i_scl),
    .i_sda     (i_sda),
    .o_sda     (sda_s),
    .o_scl_rise(scl_rise),
    .o_scl_fall(scl_fall),
    .o_start   (start),
    .o_stop    (stop)
  );

  assign byte_in  = {shift_q[6:0], sda_s};
  assign last     = cnt_q == 3'd0;
  assign addr_hit = byte_in[7:1] == ADDR7;
  assign in_rx    = state_q inside {S_ADDR, S_REG, S_WDATA};
  assign in_ack   = is_ack(state_q);

  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state_q <= S_IDLE;
    else state_q <= state_d;

  // next state: bus conditions override everything; ACK states leave on their second SCL fall
  always_comb begin
    state_d = state_q;
    if (stop) state_d = S_IDLE;
    else if (start) state_d = S_ADDR;
    else
      case (state_q)
        S_IDLE:      state_d = S_IDLE;
        S_ADDR:      if (scl_rise && last) state_d = addr_hit ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK:  if (scl_fall && phase_q) state_d = shift_q[0] ? S_RDATA : S_REG;
        S_REG:       if (scl_rise && last) state_d = S_REG_ACK;
        S_REG_ACK:   if (scl_fall && phase_q) state_d = S_WDATA;
        S_WDATA:     if (scl_rise && last) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall && phase_q) state_d = S_WDATA;
        S_RDATA:     if (scl_fall && last) state_d = S_RACK;
        S_RACK:      if (scl_rise && sda_s) state_d = S_IDLE;
                     else if (scl_fall && phase_q) state_d = S_RDATA;
        default:     state_d = S_IDLE;
      endcase
  end

  // datapath next values: bit counter wraps 0->7 so every byte starts at bit 7 without reload
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    cfg_d       = cfg_q;
    cfg_wr_d    = 1'b0;
    snap_int_d  = snap_int_q;
    snap_frac_d = snap_frac_q;
    if (scl_rise && in_rx) begin
      shift_d = byte_in;
      cnt_d   = cnt_q - 3'd1;
    end
    if (scl_fall && state_q == S_RDATA) begin
      tx_d  = {tx_q[6:0], 1'b0};
      cnt_d = cnt_q - 3'd1;
    end
    if (in_ack && scl_fall) phase_d = ~phase_q;
    if (state_q == S_RACK) phase_d = scl_rise ? ~sda_s : scl_fall ? 1'b0 : phase_q;
    if (state_q == S_ADDR && scl_rise && last && addr_hit && sda_s) begin
      snap_int_d  = i_temp_int;
      snap_frac_d = i_temp_frac;
    end
    if (state_q == S_REG && scl_rise && last) ptr_d = byte_in;
    if (state_q == S_WDATA && scl_rise && last) begin
      ptr_d    = ptr_q + 8'd1;
      cfg_d    = ptr_q == REG_CFG_WR ? byte_in : cfg_q;
      cfg_wr_d = ptr_q == REG_CFG_WR;
    end
    if (state_q == S_RDATA && scl_fall && last) ptr_d = ptr_q + 8'd1;
    if (state_d == S_RDATA && state_q != S_RDATA) tx_d = reg_read(ptr_q, snap_int_q, snap_frac_q, cfg_q);
    if (start || stop) begin
      cnt_d   = 3'd7;
      phase_d = 1'b0;
    end
  end

  // busy rises on an address match and drops whenever the target returns to IDLE
  always_comb begin
    busy_d = (state_q == S_ADDR && state_d == S_ADDR_ACK) ? 1'b1 : state_d == S_IDLE ? 1'b0 : busy_q;
  end

  // datapath registers
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      cnt_q       <= 3'd7;
      shift_q     <= '0;
      phase_q     <= 1'b0;
      ptr_q       <= '0;
      tx_q        <= '1;
      cfg_q       <= CFG_RESET;
      cfg_wr_q    <= 1'b0;
      snap_int_q  <= '0;
      snap_frac_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      cfg_q       <= cfg_d;
      cfg_wr_q    <= cfg_wr_d;
      snap_int_q  <= snap_int_d;
      snap_frac_q <= snap_frac_d;
      busy_q      <= busy_d;
    end

  // SDA pull-down from registered state only, so reset releases the line immediately
  always_comb begin
    o_sda_oe = (in_ack && phase_q) || (state_q == S_RDATA && !tx_q[7]);
  end

  assign o_cfg    = cfg_q;
  assign o_cfg_wr = cfg_wr_q;
  assign o_busy   = busy_q;
endmodule

// File: tb/tb_i2c_sensor_target.sv
// tb_i2c_sensor_target: randomized I2C controller with scoreboard against a register-map model
module tb_i2c_sensor_target;
  localparam int Q = 50;
  typedef struct { logic [7:0] val; string tag; } exp_t;

  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
  logic [7:0] temp_int = 8'h00, temp_frac = 8'h00;
  logic oe, cfg_wr, busy, sda_line;
  logic [7:0] cfg;
  assign sda_line = m_sda & ~oe;

  i2c_sensor_target dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_scl      (scl),
    .i_sda      (sda_line),
    .o_sda_oe   (oe),
    .i_temp_int (temp_int),
    .i_temp_frac(temp_frac),
    .o_cfg      (cfg),
    .o_cfg_wr   (cfg_wr),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, oe_cnt = 0;
  exp_t exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] cfg_exp_q[$];
  logic [7:0] wbuf [4];
  logic [7:0] picks [6] = '{8'h00, 8'h0F, 8'h03, 8'h09, 8'hFE, 8'hFF};
  logic [7:0] ptr_m = 8'h00, cfg_m = 8'h00, snap_int_m = 8'h00, snap_frac_m = 8'h00;

  function automatic void chk(input string n, input logic [7:0] a, input logic [7:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", n, a, e);
  endfunction

  function automatic logic [7:0] model_rd(input logic [7:0] p);
    return p == 8'h00 ? snap_int_m : p == 8'h0F ? snap_frac_m : p == 8'h03 ? cfg_m : 8'h00;
  endfunction

  function automatic void push(input string tag, input logic [7:0] e, input logic [7:0] o);
    exp_t x;
    x.val = e;
    x.tag = tag;
    exp_q.push_back(x);
    obs_q.push_back(o);
  endfunction

  always @(posedge clk) if (oe) oe_cnt <= oe_cnt + 1;

  always @(negedge clk) begin
    exp_t x;
    logic [7:0] o;
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      x = exp_q.pop_front();
      o = obs_q.pop_front();
      chk(x.tag, o, x.val);
    end
    if (cfg_wr) begin
      if (cfg_exp_q.size() == 0) chk("cfg_wr_extra", 8'(cfg_wr), 8'h00);
      else chk("cfg_write", cfg, cfg_exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic bit_out(input logic b);
    m_sda = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask
  task automatic bus_start();
    m_sda = 1'b1; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask
  task automatic bus_rstart();
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
  endtask
  task automatic bus_stop();
    m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
  endtask
  task automatic wr_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    m_sda = 1'b1; #Q; scl = 1'b1; #Q; a = ~sda_line; #Q; scl = 1'b0; #Q;
    push(tag, 8'(exp_ack), 8'(a));
  endtask
  task automatic rd_byte(input logic ack, output logic [7:0] d);
    m_sda = 1'b1;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #Q; scl = 1'b1; #Q; d = {d[6:0], sda_line}; #Q; scl = 1'b0;
    end
    #Q; m_sda = ~ack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; m_sda = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [7:0] p, input int nd, input bit stop_after);
    logic ok;
    int oe0;
    ok = ab == 8'h9C;
    oe0 = oe_cnt;
    bus_start();
    wr_byte(ab, ok, "addr_w_ack");
    chk("busy_after_addr", 8'(busy), 8'(ok));
    if (ok) begin
      wr_byte(p, 1'b1, "reg_ack");
      ptr_m = p;
      for (int i = 0; i < nd; i++) begin
        if (ptr_m == 8'h09) begin
          cfg_m = wbuf[i];
          cfg_exp_q.push_back(wbuf[i]);
        end
        ptr_m++;
        wr_byte(wbuf[i], 1'b1, "wdata_ack");
      end
    end
    if (stop_after) begin
      bus_stop();
      chk("busy_after_stop", 8'(busy), 8'h00);
      if (!ok) chk("sda_released_on_miss", 8'(oe_cnt - oe0), 8'h00);
    end
  endtask

  task automatic do_read(input int n, input bit rep);
    logic [7:0] d, e;
    if (rep) bus_rstart();
    else bus_start();
    snap_int_m  = temp_int;
    snap_frac_m = temp_frac;
    wr_byte(8'h9D, 1'b1, "addr_r_ack");
    chk("busy_read", 8'(busy), 8'h01);
    for (int i = 0; i < n; i++) begin
      e = model_rd(ptr_m);
      ptr_m++;
      rd_byte(i < n - 1, d);
      push("rdata", e, d);
      temp_int  = 8'($urandom);
      temp_frac = 8'($urandom);
    end
    chk("busy_after_nack", 8'(busy), 8'h00);
    bus_stop();
  endtask

  initial begin
    logic [7:0] e, ab;
    int k;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_oe", 8'(oe), 8'h00);
    chk("rst_cfg", cfg, 8'h00);
    chk("rst_cfg_wr", 8'(cfg_wr), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    wbuf[0] = 8'h5A;
    do_write(8'h9C, 8'h09, 1, 1'b1);
    chk("cfg_value", cfg, 8'h5A);

    temp_int = 8'h19; temp_frac = 8'h80;
    do_write(8'h9C, 8'h00, 0, 1'b0);
    do_read(2, 1'b1);

    do_write(8'h90, 8'h00, 0, 1'b1);

    temp_int = 8'h00;
    do_write(8'h9C, 8'hFF, 0, 1'b0);
    do_read(2, 1'b1);

    do_write(8'h9C, 8'h03, 0, 1'b0);
    do_read(1, 1'b1);

    temp_int = 8'h19;
    do_write(8'h9C, 8'h00, 0, 1'b0);
    bus_rstart();
    snap_int_m  = temp_int;
    snap_frac_m = temp_frac;
    wr_byte(8'h9D, 1'b1, "addr_r_ack");
    e = ~model_rd(ptr_m);
    chk("drive_bit7", 8'(oe), 8'(e[7]));
    #3 rst = 1'b1;
    #1 chk("rst_async_release", 8'(oe), 8'h00);
    scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    ptr_m = 8'h00; cfg_m = 8'h00; snap_int_m = 8'h00; snap_frac_m = 8'h00;
    repeat (4) @(posedge clk);
    chk("rst_mid_cfg", cfg, 8'h00);
    chk("rst_mid_busy", 8'(busy), 8'h00);
    temp_int = 8'($urandom); temp_frac = 8'($urandom);
    do_read(2, 1'b0);
    wbuf[0] = 8'($urandom);
    do_write(8'h9C, 8'h09, 1, 1'b1);
    do_write(8'h9C, 8'h03, 0, 1'b0);
    do_read(1, 1'b1);

    repeat (15) begin
      k = $urandom_range(0, 3);
      temp_int = 8'($urandom); temp_frac = 8'($urandom);
      if (k == 0) begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(8'h9C, $urandom_range(0, 1) != 0 ? 8'h09 : 8'($urandom_range(6, 9)), $urandom_range(1, 3), 1'b1);
      end else if (k == 1) begin
        do_write(8'h9C, picks[$urandom_range(0, 5)], 0, 1'b0);
        do_read($urandom_range(1, 3), 1'b1);
      end else if (k == 2) begin
        do_read($urandom_range(1, 3), 1'b0);
      end else begin
        ab = 8'($urandom);
        if (ab[7:1] == 7'h4E) ab = ab ^ 8'h02;
        do_write(ab, 8'h00, 0, 1'b1);
      end
    end

    for (int i = 0; i < 50 && (exp_q.size() != 0 || obs_q.size() != 0 || cfg_exp_q.size() != 0); i++) @(posedge clk);
    chk("scoreboard_drained", 8'(exp_q.size() + obs_q.size() + cfg_exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
